// File: rtl/rob_pkg.sv
// Shared types for the multi-channel reorder buffer: kind codes, entry payload, next-pc helper.
package rob_pkg;

  typedef enum logic [2:0] {
    KIND_ALU    = 3'd0,
    KIND_BRANCH = 3'd1,
    KIND_JALR   = 3'd2,
    KIND_LOAD   = 3'd3,
    KIND_STORE  = 3'd4,
    KIND_EXIT   = 3'd5
  } rob_kind_e;

  typedef struct packed {
    logic        valid;
    logic        done;
    rob_kind_e   kind;
    logic        pred;
    logic        is_c;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] value;
    logic [31:0] target;
  } rob_entry_t;

  // Fetch restart address after a resolved branch.
  function automatic logic [31:0] branch_next_pc(input logic [31:0] pc, input logic [31:0] imm,
                                                 input logic taken, input logic is_c);
    if (taken) return pc + imm;
    return pc + (is_c ? 32'd2 : 32'd4);
  endfunction

endpackage

// File: rtl/reorder_buffer_mc_wb_select.sv
// Lowest-channel writeback match for one entry id, with the winning channel's value.
module rob_wb_select #(
  parameter int unsigned ID_W   = 4,
  parameter int unsigned NUM_WB = 3
) (
  input  logic [ID_W-1:0]        id,
  input  logic [NUM_WB-1:0]      wb_valid,
  input  logic [NUM_WB*ID_W-1:0] wb_id,
  input  logic [NUM_WB*32-1:0]   wb_value,
  output logic                   hit,
  output logic [31:0]            value
);

  // Scan from the highest channel down so the lowest matching channel is the last writer.
  always_comb begin
    hit   = 1'b0;
    value = '0;
    for (int i = int'(NUM_WB) - 1; i >= 0; i--) begin
      if (wb_valid[i] && (wb_id[i*ID_W +: ID_W] == id)) begin
        hit   = 1'b1;
        value = wb_value[i*32 +: 32];
      end
    end
  end

endmodule

// File: rtl/reorder_buffer_mc.sv
// In-order commit reorder buffer with N writeback channels, operand bypass,
// store-commit handshake and single-cycle precise flush on branch mispredict.
module reorder_buffer_mc
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ID_W   = $clog2(DEPTH),
  parameter int unsigned REG_W  = 5,
  parameter int unsigned NUM_WB = 3
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   alloc_valid,
  input  logic [2:0]             alloc_kind,
  input  logic [REG_W-1:0]       alloc_rd,
  input  logic [31:0]            alloc_pc,
  input  logic [31:0]            alloc_imm,
  input  logic                   alloc_pred,
  input  logic                   alloc_is_c,
  output logic                   full,
  output logic [ID_W-1:0]        alloc_id,
  input  logic [NUM_WB-1:0]      wb_valid,
  input  logic [NUM_WB*ID_W-1:0] wb_id,
  input  logic [NUM_WB*32-1:0]   wb_value,
  input  logic [31:0]            wb_target,
  input  logic [ID_W-1:0]        q1_id,
  input  logic [ID_W-1:0]        q2_id,
  output logic                   q1_ready,
  output logic                   q2_ready,
  output logic [31:0]            q1_value,
  output logic [31:0]            q2_value,
  output logic                   commit_valid,
  output logic [REG_W-1:0]       commit_rd,
  output logic [ID_W-1:0]        commit_id,
  output logic [31:0]            commit_value,
  output logic                   store_req,
  input  logic                   store_ack,
  output logic                   br_valid,
  output logic [31:0]            br_pc,
  output logic                   br_pred,
  output logic                   br_taken,
  output logic                   redirect_valid,
  output logic [31:0]            pc_next,
  output logic                   flush,
  output logic [ID_W-1:0]        head_id,
  output logic                   halt
);

  localparam int unsigned CNT_W = ID_W + 1;

  rob_entry_t       ent    [DEPTH];
  logic [REG_W-1:0] ent_rd [DEPTH];
  logic [ID_W-1:0]  head, tail;
  logic [CNT_W-1:0] count;

  logic [DEPTH-1:0] wb_hit;
  logic [31:0]      wb_val [DEPTH];
  logic             q1_hit, q2_hit;
  logic [31:0]      q1_byp, q2_byp;

  rob_entry_t       head_ent;
  logic             head_ready_c, commit_c, mispredict_c, kill_c, alloc_c;
  logic [CNT_W-1:0] count_next;

  assign alloc_id = tail;
  assign head_id  = head;

  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_wb
    rob_wb_select #(.ID_W(ID_W), .NUM_WB(NUM_WB)) u_sel (
      .id       (ID_W'(g)),
      .wb_valid (wb_valid),
      .wb_id    (wb_id),
      .wb_value (wb_value),
      .hit      (wb_hit[g]),
      .value    (wb_val[g])
    );
  end

  rob_wb_select #(.ID_W(ID_W), .NUM_WB(NUM_WB)) u_q1 (
    .id(q1_id), .wb_valid(wb_valid), .wb_id(wb_id), .wb_value(wb_value),
    .hit(q1_hit), .value(q1_byp)
  );

  rob_wb_select #(.ID_W(ID_W), .NUM_WB(NUM_WB)) u_q2 (
    .id(q2_id), .wb_valid(wb_valid), .wb_id(wb_id), .wb_value(wb_value),
    .hit(q2_hit), .value(q2_byp)
  );

  // Operand queries: stored result first, else this cycle's writeback.
  always_comb begin
    q1_ready = ent[q1_id].done || q1_hit;
    q2_ready = ent[q2_id].done || q2_hit;
    q1_value = ent[q1_id].done ? ent[q1_id].value : (q1_hit ? q1_byp : 32'd0);
    q2_value = ent[q2_id].done ? ent[q2_id].value : (q2_hit ? q2_byp : 32'd0);
  end

  // Commit, flush and allocation decisions for this cycle.
  always_comb begin
    head_ent     = ent[head];
    head_ready_c = head_ent.valid && head_ent.done && !halt;
    commit_c     = head_ready_c &&
                   ((head_ent.kind != KIND_STORE) || (store_req && store_ack));
    mispredict_c = commit_c && (head_ent.kind == KIND_BRANCH) &&
                   (head_ent.value[0] != head_ent.pred);
    kill_c       = mispredict_c || flush;
    alloc_c      = alloc_valid && !full && !flush && !halt && !mispredict_c;
    count_next   = count + CNT_W'(alloc_c) - CNT_W'(commit_c);
    if (mispredict_c) count_next = '0;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      full           <= 1'b0;
      commit_valid   <= 1'b0;
      commit_rd      <= '0;
      commit_id      <= '0;
      commit_value   <= '0;
      store_req      <= 1'b0;
      br_valid       <= 1'b0;
      br_pc          <= '0;
      br_pred        <= 1'b0;
      br_taken       <= 1'b0;
      redirect_valid <= 1'b0;
      pc_next        <= '0;
      flush          <= 1'b0;
      halt           <= 1'b0;
      for (int e = 0; e < int'(DEPTH); e++) begin
        ent[e]    <= '0;
        ent_rd[e] <= '0;
      end
    end else if (rdy_in) begin
      commit_valid   <= 1'b0;
      br_valid       <= 1'b0;
      redirect_valid <= 1'b0;
      flush          <= 1'b0;
      store_req      <= head_ready_c && (head_ent.kind == KIND_STORE) && !commit_c;

      for (int e = 0; e < int'(DEPTH); e++) begin
        if (!kill_c && wb_hit[e] && ent[e].valid && !ent[e].done) begin
          ent[e].done  <= 1'b1;
          ent[e].value <= wb_val[e];
          // Only the RS channel carries a jump target.
          if (wb_valid[0] && (wb_id[ID_W-1:0] == ID_W'(e))) ent[e].target <= wb_target;
        end
      end

      if (commit_c) begin
        ent[head].valid <= 1'b0;
        head            <= head + ID_W'(1);
        case (head_ent.kind)
          KIND_ALU, KIND_LOAD, KIND_JALR: begin
            commit_valid <= 1'b1;
            commit_rd    <= ent_rd[head];
            commit_id    <= head;
            commit_value <= head_ent.value;
            if (head_ent.kind == KIND_JALR) begin
              redirect_valid <= 1'b1;
              pc_next        <= head_ent.target;
            end
          end
          KIND_STORE: begin
            commit_valid <= 1'b1;
            commit_rd    <= '0;
            commit_id    <= head;
            commit_value <= head_ent.value;
          end
          KIND_BRANCH: begin
            br_valid <= 1'b1;
            br_pc    <= head_ent.pc;
            br_pred  <= head_ent.pred;
            br_taken <= head_ent.value[0];
            if (mispredict_c) begin
              flush          <= 1'b1;
              redirect_valid <= 1'b1;
              pc_next        <= branch_next_pc(head_ent.pc, head_ent.imm,
                                               head_ent.value[0], head_ent.is_c);
            end
          end
          KIND_EXIT: halt <= 1'b1;
          default: ;
        endcase
      end

      if (alloc_c) begin
        ent[tail] <= '{valid: 1'b1, done: 1'b0, kind: rob_kind_e'(alloc_kind),
                       pred: alloc_pred, is_c: alloc_is_c, pc: alloc_pc,
                       imm: alloc_imm, value: 32'd0, target: 32'd0};
        ent_rd[tail] <= alloc_rd;
        tail         <= tail + ID_W'(1);
      end

      count <= count_next;
      full  <= (count_next == CNT_W'(DEPTH));

      // Precise flush: every in-flight entry is squashed at the resolving edge.
      if (mispredict_c) begin
        head <= '0;
        tail <= '0;
        for (int e = 0; e < int'(DEPTH); e++) begin
          ent[e].valid <= 1'b0;
          ent[e].done  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer_mc.sv
// Directed bench for reorder_buffer_mc with a queue-based reference model and literal spot checks.
module tb_reorder_buffer_mc;
  import rob_pkg::*;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ID_W   = 2;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned NUM_WB = 3;

  logic clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1;
  logic alloc_valid = 1'b0, alloc_pred = 1'b0, alloc_is_c = 1'b0;
  logic [2:0] alloc_kind = '0;
  logic [REG_W-1:0] alloc_rd = '0;
  logic [31:0] alloc_pc = '0, alloc_imm = '0, wb_target = '0;
  logic full, q1_ready, q2_ready, commit_valid, store_req, br_valid, br_pred, br_taken;
  logic redirect_valid, flush, halt;
  logic [ID_W-1:0] alloc_id, commit_id, head_id;
  logic [ID_W-1:0] q1_id = '0, q2_id = '0;
  logic [NUM_WB-1:0] wb_valid = '0;
  logic [NUM_WB*ID_W-1:0] wb_id = '0;
  logic [NUM_WB*32-1:0] wb_value = '0;
  logic [31:0] q1_value, q2_value, commit_value, br_pc, pc_next;
  logic [REG_W-1:0] commit_rd;
  logic store_ack = 1'b0;

  reorder_buffer_mc #(.DEPTH(DEPTH), .ID_W(ID_W), .REG_W(REG_W), .NUM_WB(NUM_WB)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .alloc_valid(alloc_valid), .alloc_kind(alloc_kind), .alloc_rd(alloc_rd),
    .alloc_pc(alloc_pc), .alloc_imm(alloc_imm), .alloc_pred(alloc_pred),
    .alloc_is_c(alloc_is_c), .full(full), .alloc_id(alloc_id),
    .wb_valid(wb_valid), .wb_id(wb_id), .wb_value(wb_value), .wb_target(wb_target),
    .q1_id(q1_id), .q2_id(q2_id), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_value(q1_value), .q2_value(q2_value),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_id(commit_id),
    .commit_value(commit_value), .store_req(store_req), .store_ack(store_ack),
    .br_valid(br_valid), .br_pc(br_pc), .br_pred(br_pred), .br_taken(br_taken),
    .redirect_valid(redirect_valid), .pc_next(pc_next), .flush(flush),
    .head_id(head_id), .halt(halt)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: ROB as a queue of live instructions ----------------
  typedef struct {
    logic [ID_W-1:0] id;
    logic [2:0]      kind;
    logic [4:0]      rd;
    logic [31:0]     pc, imm, value, target;
    logic            pred, is_c, done;
  } m_ent_t;

  m_ent_t mq[$];
  int m_head = 0, m_tail = 0;
  logic e_full = 0, e_commit_valid = 0, e_store_req = 0, e_br_valid = 0, e_br_pred = 0;
  logic e_br_taken = 0, e_redirect_valid = 0, e_flush = 0, e_halt = 0;
  logic [4:0] e_commit_rd = '0;
  logic [ID_W-1:0] e_commit_id = '0;
  logic [31:0] e_commit_value = '0, e_br_pc = '0, e_pc_next = '0;
  logic m_prev_flush, m_commit, m_mis, m_sreq, m_taken;
  logic [DEPTH-1:0] m_claimed;
  logic [ID_W-1:0] m_wid;
  m_ent_t m_h;

  always @(posedge clk_in) begin
    cyc++;
    if (rst_in) begin
      mq.delete();
      m_head = 0; m_tail = 0;
      e_full = 0; e_commit_valid = 0; e_store_req = 0; e_br_valid = 0; e_br_pred = 0;
      e_br_taken = 0; e_redirect_valid = 0; e_flush = 0; e_halt = 0;
      e_commit_rd = '0; e_commit_id = '0; e_commit_value = '0; e_br_pc = '0; e_pc_next = '0;
    end else if (rdy_in) begin
      m_prev_flush = e_flush;
      e_commit_valid = 0; e_br_valid = 0; e_redirect_valid = 0; e_flush = 0;
      m_commit = 0; m_mis = 0; m_sreq = 0;
      if (mq.size() > 0 && mq[0].done && !e_halt) begin
        m_commit = (mq[0].kind != 3'(KIND_STORE)) || (e_store_req && store_ack);
        m_sreq = (mq[0].kind == 3'(KIND_STORE)) && !m_commit;
        m_mis = m_commit && (mq[0].kind == 3'(KIND_BRANCH)) && (mq[0].value[0] != mq[0].pred);
      end
      if (!(m_mis || m_prev_flush)) begin
        m_claimed = '0;
        for (int c = 0; c < int'(NUM_WB); c++) begin
          m_wid = wb_id[c*ID_W +: ID_W];
          if (wb_valid[c] && !m_claimed[m_wid]) begin
            m_claimed[m_wid] = 1'b1;
            foreach (mq[k]) if (mq[k].id == m_wid && !mq[k].done) begin
              mq[k].done = 1'b1;
              mq[k].value = wb_value[c*32 +: 32];
              if (c == 0) mq[k].target = wb_target;
            end
          end
        end
      end
      if (m_commit) begin
        m_h = mq.pop_front();
        m_head = (m_head + 1) % DEPTH;
        m_taken = m_h.value[0];
        if (m_h.kind == 3'(KIND_ALU) || m_h.kind == 3'(KIND_LOAD) || m_h.kind == 3'(KIND_JALR) ||
            m_h.kind == 3'(KIND_STORE)) begin
          e_commit_valid = 1;
          e_commit_rd = (m_h.kind == 3'(KIND_STORE)) ? 5'd0 : m_h.rd;
          e_commit_id = m_h.id;
          e_commit_value = m_h.value;
          if (m_h.kind == 3'(KIND_JALR)) begin e_redirect_valid = 1; e_pc_next = m_h.target; end
        end else if (m_h.kind == 3'(KIND_BRANCH)) begin
          e_br_valid = 1; e_br_pc = m_h.pc; e_br_pred = m_h.pred; e_br_taken = m_taken;
          if (m_mis) begin
            e_flush = 1; e_redirect_valid = 1;
            e_pc_next = m_taken ? m_h.pc + m_h.imm : m_h.pc + (m_h.is_c ? 32'd2 : 32'd4);
          end
        end else if (m_h.kind == 3'(KIND_EXIT)) begin
          e_halt = 1;
        end
      end
      if (alloc_valid && !e_full && !m_prev_flush && !e_halt && !m_mis) begin
        mq.push_back('{id: ID_W'(m_tail), kind: alloc_kind, rd: alloc_rd, pc: alloc_pc,
                       imm: alloc_imm, value: 32'd0, target: 32'd0, pred: alloc_pred,
                       is_c: alloc_is_c, done: 1'b0});
        m_tail = (m_tail + 1) % DEPTH;
      end
      if (m_mis) begin mq.delete(); m_head = 0; m_tail = 0; end
      e_store_req = m_sreq;
      e_full = (mq.size() == DEPTH);
    end
  end

  task automatic m_query(input logic [ID_W-1:0] id, output bit live, output logic rdy,
                         output logic [31:0] val);
    logic hit = 1'b0;
    logic [31:0] bv = '0;
    live = 0; rdy = 0; val = '0;
    for (int c = int'(NUM_WB) - 1; c >= 0; c--)
      if (wb_valid[c] && wb_id[c*ID_W +: ID_W] == id) begin hit = 1'b1; bv = wb_value[c*32 +: 32]; end
    foreach (mq[k]) if (mq[k].id == id) begin
      live = 1;
      rdy = mq[k].done || hit;
      val = mq[k].done ? mq[k].value : (hit ? bv : 32'd0);
    end
  endtask

  typedef struct { logic [4:0] rd; logic [31:0] value; int c; } clog_t;
  clog_t clog[$];
  bit ql; logic qr; logic [31:0] qv;

  // Cycle-by-cycle comparison against the model, plus an event log for the directed checks.
  always @(negedge clk_in) begin
    chk("full", full, e_full);
    chk("alloc_id", alloc_id, m_tail);
    chk("head_id", head_id, m_head);
    chk("halt", halt, e_halt);
    chk("store_req", store_req, e_store_req);
    chk("flush", flush, e_flush);
    chk("commit_valid", commit_valid, e_commit_valid);
    chk("br_valid", br_valid, e_br_valid);
    chk("redirect_valid", redirect_valid, e_redirect_valid);
    if (e_commit_valid) begin
      chk("commit_rd", commit_rd, e_commit_rd);
      chk("commit_id", commit_id, e_commit_id);
      chk("commit_value", commit_value, e_commit_value);
    end
    if (e_br_valid) begin
      chk("br_pc", br_pc, e_br_pc);
      chk("br_pred", br_pred, e_br_pred);
      chk("br_taken", br_taken, e_br_taken);
    end
    if (e_redirect_valid) chk("pc_next", pc_next, e_pc_next);
    m_query(q1_id, ql, qr, qv);
    if (ql) begin chk("q1_ready", q1_ready, qr); chk("q1_value", q1_value, qv); end
    m_query(q2_id, ql, qr, qv);
    if (ql) begin chk("q2_ready", q2_ready, qr); chk("q2_value", q2_value, qv); end
    if (commit_valid) clog.push_back('{rd: commit_rd, value: commit_value, c: cyc});
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk_in); #2;
    alloc_valid = 1'b0; wb_valid = '0; store_ack = 1'b0;
  endtask

  task automatic alloc_set(input logic [2:0] k, input logic [4:0] rd, input logic [31:0] pc,
                           input logic [31:0] imm, input logic pred, input logic is_c);
    alloc_valid = 1'b1; alloc_kind = k; alloc_rd = rd; alloc_pc = pc;
    alloc_imm = imm; alloc_pred = pred; alloc_is_c = is_c;
  endtask

  task automatic alloc(input logic [2:0] k, input logic [4:0] rd, input logic [31:0] pc,
                       input logic [31:0] imm, input logic pred, input logic is_c);
    alloc_set(k, rd, pc, imm, pred, is_c);
    step();
  endtask

  task automatic wb_set(input int ch, input logic [ID_W-1:0] id, input logic [31:0] v);
    wb_valid[ch] = 1'b1;
    wb_id[ch*ID_W +: ID_W] = id;
    wb_value[ch*32 +: 32] = v;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    clog.delete();
  endtask

  initial begin
    step(); step();
    @(negedge clk_in);
    chk("rst_full", full, 0);
    chk("rst_alloc_id", alloc_id, 0);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_halt", halt, 0);
    chk("rst_store_req", store_req, 0);
    chk("rst_flush", flush, 0);
    rst_in = 1'b0;

    // In-order commit of out-of-order writebacks; a frozen cycle drops its writeback.
    alloc(3'(KIND_ALU), 5, 32'h0, 0, 0, 0);
    alloc(3'(KIND_ALU), 6, 32'h4, 0, 0, 0);
    alloc(3'(KIND_ALU), 7, 32'h8, 0, 0, 0);
    rdy_in = 1'b0; wb_set(0, 0, 32'h99); step(); rdy_in = 1'b1;
    wb_set(0, 2, 32'h30); step();
    wb_set(0, 0, 32'h10); step();
    wb_set(0, 1, 32'h20); step();
    step(); step(); step();
    chk("t1_commit_count", clog.size(), 3);
    if (clog.size() == 3) begin
      chk("t1_c0_rd", clog[0].rd, 5);  chk("t1_c0_val", clog[0].value, 32'h10);
      chk("t1_c1_rd", clog[1].rd, 6);  chk("t1_c1_val", clog[1].value, 32'h20);
      chk("t1_c2_rd", clog[2].rd, 7);  chk("t1_c2_val", clog[2].value, 32'h30);
      chk("t1_consec01", clog[1].c - clog[0].c, 1);
      chk("t1_consec12", clog[2].c - clog[1].c, 1);
    end

    // Full at DEPTH, tail wrap, registered full release.
    do_reset();
    for (int i = 1; i <= 4; i++) alloc(3'(KIND_ALU), 5'(i), 32'(i * 4), 0, 0, 0);
    @(negedge clk_in);
    chk("t2_full", full, 1);
    chk("t2_tail_wrap", alloc_id, 0);
    alloc(3'(KIND_ALU), 9, 32'h40, 0, 0, 0);
    @(negedge clk_in);
    chk("t2_full_hold", full, 1);
    chk("t2_5th_ignored", alloc_id, 0);
    wb_set(1, 0, 32'h55); step(); step();
    @(negedge clk_in);
    chk("t2_commit", commit_valid, 1);
    chk("t2_commit_rd", commit_rd, 1);
    chk("t2_commit_val", commit_value, 32'h55);
    chk("t2_full_clear", full, 0);
    chk("t2_next_id", alloc_id, 0);
    alloc(3'(KIND_ALU), 10, 32'h44, 0, 0, 0);
    @(negedge clk_in);
    chk("t2_refill_full", full, 1);
    chk("t2_refill_id", alloc_id, 1);

    // Taken mispredict with younger entries; same-cycle and flush-cycle alloc/wb dropped.
    do_reset();
    alloc(3'(KIND_BRANCH), 0, 32'h100, 32'h40, 0, 0);
    alloc(3'(KIND_ALU), 1, 32'h104, 0, 0, 0);
    alloc(3'(KIND_ALU), 2, 32'h108, 0, 0, 0);
    wb_set(0, 0, 32'h1); step();
    alloc_set(3'(KIND_ALU), 3, 32'h10c, 0, 0, 0); wb_set(1, 1, 32'h77); step();
    @(negedge clk_in);
    chk("t3_br_valid", br_valid, 1);
    chk("t3_br_pc", br_pc, 32'h100);
    chk("t3_br_taken", br_taken, 1);
    chk("t3_br_pred", br_pred, 0);
    chk("t3_flush", flush, 1);
    chk("t3_redirect", redirect_valid, 1);
    chk("t3_pc_next", pc_next, 32'h140);
    chk("t3_alloc_id", alloc_id, 0);
    chk("t3_head_id", head_id, 0);
    chk("t3_model_empty", mq.size(), 0);
    alloc_set(3'(KIND_ALU), 4, 32'h140, 0, 0, 0); wb_set(0, 0, 32'h66); step();
    @(negedge clk_in);
    chk("t3_flush_drop_alloc", alloc_id, 0);
    chk("t3_flush_done", flush, 0);
    step(); step();
    chk("t3_no_commits", clog.size(), 0);

    // Compressed not-taken mispredict.
    do_reset();
    alloc(3'(KIND_BRANCH), 0, 32'h200, 32'h80, 1, 1);
    wb_set(0, 0, 32'h0); step(); step();
    @(negedge clk_in);
    chk("t4_flush", flush, 1);
    chk("t4_pc_next", pc_next, 32'h202);
    chk("t4_br_taken", br_taken, 0);

    // Store handshake: request held without ack, commit on ack; reset kills a pending request.
    do_reset();
    alloc(3'(KIND_STORE), 0, 32'h300, 0, 0, 0);
    wb_set(2, 0, 32'h1234); step();
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk_in);
      chk("t5_store_req_wait", store_req, 1);
      chk("t5_no_commit", commit_valid, 0);
    end
    store_ack = 1'b1; step();
    @(negedge clk_in);
    chk("t5_commit", commit_valid, 1);
    chk("t5_commit_rd", commit_rd, 0);
    chk("t5_commit_val", commit_value, 32'h1234);
    chk("t5_req_drop", store_req, 0);
    alloc(3'(KIND_STORE), 0, 32'h304, 0, 0, 0);
    wb_set(0, 1, 32'h5); step(); step();
    @(negedge clk_in);
    chk("t5_req_pending", store_req, 1);
    do_reset();
    @(negedge clk_in);
    chk("t5_rst_req", store_req, 0);
    chk("t5_rst_head", head_id, 0);

    // Channel priority with bypass, then EXIT halts the machine.
    do_reset();
    alloc(3'(KIND_ALU), 3, 32'h400, 0, 0, 0);
    alloc(3'(KIND_ALU), 4, 32'h404, 0, 0, 0);
    alloc(3'(KIND_EXIT), 0, 32'h408, 0, 0, 0);
    q1_id = 1;
    wb_set(0, 1, 32'hAA); wb_set(2, 1, 32'hBB);
    #1;
    chk("t6_byp_ready", q1_ready, 1);
    chk("t6_byp_value", q1_value, 32'hAA);
    step();
    @(negedge clk_in);
    chk("t6_stored_ready", q1_ready, 1);
    chk("t6_stored_value", q1_value, 32'hAA);
    wb_set(1, 0, 32'h11); wb_set(0, 2, 32'h0); step();
    repeat (5) step();
    chk("t6_commit_count", clog.size(), 2);
    if (clog.size() == 2) begin
      chk("t6_c0_rd", clog[0].rd, 3);  chk("t6_c0_val", clog[0].value, 32'h11);
      chk("t6_c1_rd", clog[1].rd, 4);  chk("t6_c1_val", clog[1].value, 32'hAA);
    end
    chk("t6_halt", halt, 1);
    alloc(3'(KIND_ALU), 8, 32'h40c, 0, 0, 0);
    @(negedge clk_in);
    chk("t6_alloc_blocked", alloc_id, 3);
    chk("t6_halt_sticky", halt, 1);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
